lcd_panel_rx: RTL and testbench
===============================

Name: lcd_panel_rx

Overview:
LCD panel-side receiver, the consumer of the controller's LCDOUT interface. It samples LCDDCLK/LCDFP/LCDLP/LCDENAB/LCDVD in the HCLK domain and rebuilds frames. Each active pixel is tagged with its (x,y) coordinate and buffered in a small FIFO drained by a valid/ready handshake. It also measures line and frame geometry against programmed expectations. It is used as a bench-side monitor/scoreboard source and as a synthesizable panel model in the LCD subsystem.

Parameters:
DEPTH, 4, pixel FIFO entries (power of 2, ≥2)
CW, 11, coordinate/counter width

Ports:
ahb_clk_intf  input  1  clock, HCLK of the AHB clock interface; rising edge
reset  input  1  reset, asynchronous, active-high
lcd_dclk  input  1  panel pixel clock; asynchronous, ≤HCLK/4
lcd_fp  input  1  frame pulse (vsync), active-high
lcd_lp  input  1  line pulse (hsync), active-high
lcd_enab  input  1  data enable
lcd_vd  input  24  pixel data
exp_ppl  input  CW  expected pixels per line
exp_lpp  input  CW  expected lines per frame
sts_clr  input  1  clears sticky status, 1-cycle pulse
pix_valid  output  1  FIFO head valid
pix_ready  input  1  consumer accepts head
pix_data  output  24  head pixel
pix_x  output  CW  head column
pix_y  output  CW  head row
frame_done  output  1  1-cycle pulse at frame end
line_len_err  output  1  sticky
frame_len_err  output  1  sticky
overflow  output  1  sticky, a pixel was dropped
last_ppl  output  CW  pixel count of last completed line
last_lpp  output  CW  line count of last completed frame

Behaviour:
- Reset (async): all outputs 0, FSM = IDLE, FIFO empty, x = y = 0.
- Sync: all five LCD inputs pass through a 2-flop synchronizer as one 28-bit bundle, then a 3rd register holds the previous value. dclk_evt = s2_dclk & ~s3_dclk. Every other event is evaluated only on a cycle where dclk_evt is high.
- Latency: with the FIFO empty, pix_valid rises after the 3rd HCLK rising edge following the lcd_dclk rise.
- FSM IDLE: all input is ignored until fp is high at an event, then go to VSYNC.
- FSM VSYNC: leave on the first event with fp = 0 and go to FRAME with x = y = 0.
- FSM FRAME, enab = 1: push {x, y, vd}, then x = x+1 saturating at 2^CW-1. Saturation sets line_len_err.
- FSM FRAME, line end: enab 1→0 between consecutive events. last_ppl = x; line_len_err set if x ≠ exp_ppl; y++ (saturating); x = 0.
- FSM FRAME, frame end: fp = 1 at an event. last_lpp = y; frame_len_err set if y ≠ exp_lpp; frame_done pulses for one cycle; go to VSYNC.
- If enab = 1 on the same event that fp = 1: frame end wins and the pixel is discarded.
- lcd_lp is used for tracking only. An lp pulse while enab = 1 sets line_len_err.
- FIFO, full + push without pop: the pixel is dropped and overflow is set.
- FIFO, full + push + pop in the same cycle: both complete; occupancy is unchanged.
- FIFO, empty: pix_valid = 0; head outputs hold their last value.
- FIFO, pop: occurs when pix_valid & pix_ready.
- Head stability: pix_data/x/y are stable while pix_valid & ~pix_ready.
- Sticky flags: cleared by sts_clr. If a set condition and sts_clr occur in the same cycle, the set wins.
- Mid-operation reset: FIFO is flushed and the FSM returns to IDLE; the receiver waits for the next full frame pulse.

Decomposition:
- Shared package lcd_rx_pkg holds:
  - the typedef enum rx_state_t {IDLE, VSYNC, FRAME};
  - the typedef struct pix_entry_t {x, y, data};
  - the constants SYNC_STAGES = 2 and VD_W = 24.
- Sub-module lcd_rx_fifo: a synchronous pix_entry_t FIFO (DEPTH, full/empty, simultaneous push/pop) with the same clock and reset.

Test Plan:
- Normal frame: exp_ppl = 4, exp_lpp = 3, dclk = HCLK/4, one fp pulse, 3 lines of 4 enab pixels (vd = 0x000001..0x00000C), then fp.
  -> 12 pixels out in order, (x,y) = (0,0)…(3,2); frame_done pulses once; last_ppl = 4, last_lpp = 3; no errors.
- Backpressure: pix_ready = 0 for a whole 8-pixel line with DEPTH = 4.
  -> first 4 pixels held stable; overflow = 1; after ready, exactly pixels x = 0..3 appear.
- Line mismatch: exp_ppl = 4, second line carries 5 pixels.
  -> line_len_err = 1, last_ppl = 5, frame_len_err = 0.
- Pixels before the first fp are ignored: 8 enab pixels sent with no fp.
  -> no pix_valid; after fp → normal frame, first pixel tagged (0,0).
- Reset mid-frame: assert reset after 6 of 12 pixels with 2 still queued.
  -> pix_valid = 0 immediately; remaining pixels of that frame dropped; next frame captured correctly from (0,0).
- Clear collision: sts_clr pulses in the same cycle a frame_len_err condition fires.
  -> frame_len_err = 1; a later isolated sts_clr → 0.

Source files
------------

// File: rtl/lcd_rx_pkg.sv
// Shared types and constants for the LCD panel-side receiver.
package lcd_rx_pkg;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned VD_W        = 24;
    // Stored coordinate width; the receiver's CW must not exceed this.
    localparam int unsigned COORD_W     = 11;
    // Synchronised bundle: {dclk, fp, lp, enab, vd}
    localparam int unsigned BUNDLE_W    = VD_W + 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VSYNC = 2'd1,
        FRAME = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [VD_W-1:0]    data;
    } pix_entry_t;

endpackage

// File: rtl/lcd_rx_fifo.sv
// Synchronous pixel FIFO with simultaneous push/pop; head holds last popped entry when empty.
module lcd_rx_fifo
    import lcd_rx_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       ahb_clk_intf,
    input  logic       reset,
    input  logic       push,
    input  pix_entry_t push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output pix_entry_t head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    pix_entry_t    mem [DEPTH];
    pix_entry_t    last_q;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? last_q : mem[rd_ptr];

    // Storage, pointers, occupancy and last-popped head register
    always_ff @(posedge ahb_clk_intf or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            last_q <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                last_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_panel_rx.sv
// LCD panel-side receiver: synchronises LCDOUT, rebuilds frames, tags pixels and checks geometry.
module lcd_panel_rx
    import lcd_rx_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 11
) (
    input  logic            ahb_clk_intf,
    input  logic            reset,
    input  logic            lcd_dclk,
    input  logic            lcd_fp,
    input  logic            lcd_lp,
    input  logic            lcd_enab,
    input  logic [VD_W-1:0] lcd_vd,
    input  logic [CW-1:0]   exp_ppl,
    input  logic [CW-1:0]   exp_lpp,
    input  logic            sts_clr,
    output logic            pix_valid,
    input  logic            pix_ready,
    output logic [VD_W-1:0] pix_data,
    output logic [CW-1:0]   pix_x,
    output logic [CW-1:0]   pix_y,
    output logic            frame_done,
    output logic            line_len_err,
    output logic            frame_len_err,
    output logic            overflow,
    output logic [CW-1:0]   last_ppl,
    output logic [CW-1:0]   last_lpp
);

    localparam logic [CW-1:0] COORD_MAX = '1;

    logic [BUNDLE_W-1:0] sync_q [SYNC_STAGES];
    logic [BUNDLE_W-1:0] s2;
    logic                s3_dclk;
    logic                s_dclk, s_fp, s_lp, s_enab;
    logic [VD_W-1:0]     s_vd;
    logic                dclk_evt;

    rx_state_t           state;
    logic [CW-1:0]       x_q, y_q;
    logic                prev_enab;

    logic                push_req, line_end, frame_end, sat_err, lp_err;
    logic                line_len_set, frame_len_set, overflow_set;
    logic                fifo_full, fifo_empty, pop;
    pix_entry_t          push_entry, head;

    assign s2       = sync_q[SYNC_STAGES-1];
    assign s_dclk   = s2[BUNDLE_W-1];
    assign s_fp     = s2[BUNDLE_W-2];
    assign s_lp     = s2[BUNDLE_W-3];
    assign s_enab   = s2[BUNDLE_W-4];
    assign s_vd     = s2[VD_W-1:0];
    assign dclk_evt = s_dclk & ~s3_dclk;

    // Bundle synchroniser plus previous-dclk register for rising-edge detection
    always_ff @(posedge ahb_clk_intf or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            s3_dclk <= 1'b0;
        end else begin
            sync_q[0] <= {lcd_dclk, lcd_fp, lcd_lp, lcd_enab, lcd_vd};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            s3_dclk <= s_dclk;
        end
    end

    // Per-event decode in FRAME; a frame pulse takes priority over a coincident pixel
    always_comb begin
        push_req  = 1'b0;
        line_end  = 1'b0;
        frame_end = 1'b0;
        sat_err   = 1'b0;
        lp_err    = 1'b0;
        if (dclk_evt && state == FRAME) begin
            if (s_fp) begin
                frame_end = 1'b1;
            end else begin
                if (s_enab) begin
                    push_req = 1'b1;
                    sat_err  = (x_q == COORD_MAX);
                end else if (prev_enab) begin
                    line_end = 1'b1;
                end
                lp_err = s_lp & s_enab;
            end
        end
    end

    assign pop           = pix_valid & pix_ready;
    assign line_len_set  = sat_err | lp_err | (line_end && (x_q != exp_ppl));
    assign frame_len_set = frame_end && (y_q != exp_lpp);
    assign overflow_set  = push_req & fifo_full & ~pop;

    assign push_entry.x    = COORD_W'(x_q);
    assign push_entry.y    = COORD_W'(y_q);
    assign push_entry.data = s_vd;

    // Frame FSM, coordinate counters and geometry capture
    always_ff @(posedge ahb_clk_intf or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            prev_enab  <= 1'b0;
            last_ppl   <= '0;
            last_lpp   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (dclk_evt) begin
                prev_enab <= s_enab;
            end
            case (state)
                IDLE: begin
                    if (dclk_evt && s_fp) begin
                        state <= VSYNC;
                    end
                end
                VSYNC: begin
                    if (dclk_evt && !s_fp) begin
                        state <= FRAME;
                        x_q   <= '0;
                        y_q   <= '0;
                    end
                end
                FRAME: begin
                    if (frame_end) begin
                        last_lpp <= y_q;
                        state    <= VSYNC;
                    end else if (push_req) begin
                        if (x_q != COORD_MAX) begin
                            x_q <= x_q + 1'b1;
                        end
                    end else if (line_end) begin
                        last_ppl <= x_q;
                        x_q      <= '0;
                        if (y_q != COORD_MAX) begin
                            y_q <= y_q + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky status flags; a set in the same cycle as a clear wins
    always_ff @(posedge ahb_clk_intf or posedge reset) begin
        if (reset) begin
            line_len_err  <= 1'b0;
            frame_len_err <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            if (line_len_set) begin
                line_len_err <= 1'b1;
            end else if (sts_clr) begin
                line_len_err <= 1'b0;
            end
            if (frame_len_set) begin
                frame_len_err <= 1'b1;
            end else if (sts_clr) begin
                frame_len_err <= 1'b0;
            end
            if (overflow_set) begin
                overflow <= 1'b1;
            end else if (sts_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    lcd_rx_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .ahb_clk_intf(ahb_clk_intf),
        .reset       (reset),
        .push        (push_req),
        .push_data   (push_entry),
        .pop         (pop),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .head        (head)
    );

    assign pix_valid = ~fifo_empty;
    assign pix_data  = head.data;
    assign pix_x     = CW'(head.x);
    assign pix_y     = CW'(head.y);

endmodule

// File: tb/tb_lcd_panel_rx.sv
// Directed self-checking bench for lcd_panel_rx.
module tb_lcd_panel_rx;

    logic        ahb_clk_intf = 1'b0;
    logic        reset;
    logic        lcd_dclk, lcd_fp, lcd_lp, lcd_enab;
    logic [23:0] lcd_vd;
    logic [10:0] exp_ppl, exp_lpp;
    logic        sts_clr;
    logic        pix_valid, pix_ready;
    logic [23:0] pix_data;
    logic [10:0] pix_x, pix_y;
    logic        frame_done, line_len_err, frame_len_err, overflow;
    logic [10:0] last_ppl, last_lpp;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [23:0] d;
    } ent_t;

    ent_t popq[$];
    int   fd_cnt = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   base;
    int   fd_base;

    lcd_panel_rx #(
        .DEPTH(4),
        .CW   (11)
    ) dut (
        .ahb_clk_intf (ahb_clk_intf),
        .reset        (reset),
        .lcd_dclk     (lcd_dclk),
        .lcd_fp       (lcd_fp),
        .lcd_lp       (lcd_lp),
        .lcd_enab     (lcd_enab),
        .lcd_vd       (lcd_vd),
        .exp_ppl      (exp_ppl),
        .exp_lpp      (exp_lpp),
        .sts_clr      (sts_clr),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_data     (pix_data),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .frame_done   (frame_done),
        .line_len_err (line_len_err),
        .frame_len_err(frame_len_err),
        .overflow     (overflow),
        .last_ppl     (last_ppl),
        .last_lpp     (last_lpp)
    );

    always #5 ahb_clk_intf = ~ahb_clk_intf;

    // Record accepted pixels and frame_done pulses midway between clock edges
    always @(negedge ahb_clk_intf) begin
        if (!reset && pix_valid && pix_ready) begin
            popq.push_back({pix_x, pix_y, pix_data});
        end
        if (frame_done) begin
            fd_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2ns after a rising edge, never on it
    task automatic cyc(input int n);
        repeat (n) @(posedge ahb_clk_intf);
        #2;
    endtask

    // One lcd_dclk period of four HCLKs; data is set while dclk is low
    task automatic dtick(input logic fp, input logic lp, input logic en, input logic [23:0] vd);
        lcd_fp   = fp;
        lcd_lp   = lp;
        lcd_enab = en;
        lcd_vd   = vd;
        lcd_dclk = 1'b0;
        cyc(2);
        lcd_dclk = 1'b1;
        cyc(2);
    endtask

    // n pixels with consecutive data, then an lp pulse with enab low and one idle period
    task automatic send_line(input int n, input logic [23:0] vd0);
        for (int i = 0; i < n; i++) begin
            dtick(1'b0, 1'b0, 1'b1, vd0 + 24'(i));
        end
        dtick(1'b0, 1'b1, 1'b0, 24'h0);
        dtick(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic pulse_clr();
        sts_clr = 1'b1;
        cyc(1);
        sts_clr = 1'b0;
        cyc(1);
    endtask

    initial begin
        reset     = 1'b1;
        lcd_dclk  = 1'b0;
        lcd_fp    = 1'b0;
        lcd_lp    = 1'b0;
        lcd_enab  = 1'b0;
        lcd_vd    = '0;
        exp_ppl   = 11'd4;
        exp_lpp   = 11'd3;
        sts_clr   = 1'b0;
        pix_ready = 1'b1;
        cyc(3);

        // Reset state
        chk("rst_valid", pix_valid, 0);
        chk("rst_data", pix_data, 0);
        chk("rst_x", pix_x, 0);
        chk("rst_fdone", frame_done, 0);
        chk("rst_lerr", line_len_err, 0);
        chk("rst_ferr", frame_len_err, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ppl", last_ppl, 0);
        chk("rst_lpp", last_lpp, 0);
        reset = 1'b0;
        cyc(2);

        // Pixels before any frame pulse are ignored
        for (int i = 0; i < 8; i++) begin
            dtick(1'b0, 1'b0, 1'b1, 24'hAA0 + 24'(i));
        end
        dtick(1'b0, 1'b0, 1'b0, 24'h0);
        cyc(6);
        chk("prefp_none", popq.size(), 0);
        chk("prefp_valid", pix_valid, 0);

        // Normal frame 4x3, first pixel also checks latency
        base    = popq.size();
        fd_base = fd_cnt;
        pix_ready = 1'b0;
        dtick(1'b1, 1'b0, 1'b0, 24'h0);
        dtick(1'b0, 1'b0, 1'b0, 24'h0);
        lcd_fp = 1'b0; lcd_lp = 1'b0; lcd_enab = 1'b1; lcd_vd = 24'h1; lcd_dclk = 1'b0;
        cyc(2);
        lcd_dclk = 1'b1;
        cyc(2);
        chk("lat_edge2", pix_valid, 0);
        cyc(1);
        chk("lat_edge3", pix_valid, 1);
        chk("lat_x", pix_x, 0);
        chk("lat_y", pix_y, 0);
        chk("lat_data", pix_data, 24'h1);
        pix_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            dtick(1'b0, 1'b0, 1'b1, 24'(i + 1));
        end
        dtick(1'b0, 1'b1, 1'b0, 24'h0);
        dtick(1'b0, 1'b0, 1'b0, 24'h0);
        send_line(4, 24'h5);
        send_line(4, 24'h9);
        chk("nf_no_fdone_yet", fd_cnt - fd_base, 0);
        dtick(1'b1, 1'b0, 1'b0, 24'h0);
        dtick(1'b0, 1'b0, 1'b0, 24'h0);
        cyc(4);
        chk("nf_count", popq.size() - base, 12);
        for (int i = 0; i < 12; i++) begin
            chk("nf_x", popq[base + i].x, i % 4);
            chk("nf_y", popq[base + i].y, i / 4);
            chk("nf_data", popq[base + i].d, i + 1);
        end
        chk("nf_fdone", fd_cnt - fd_base, 1);
        chk("nf_ppl", last_ppl, 4);
        chk("nf_lpp", last_lpp, 3);
        chk("nf_lerr", line_len_err, 0);
        chk("nf_ferr", frame_len_err, 0);
        chk("nf_ovf", overflow, 0);
        chk("empty_valid", pix_valid, 0);
        chk("empty_hold_data", pix_data, 24'hC);
        chk("empty_hold_x", pix_x, 3);
        chk("empty_hold_y", pix_y, 2);

        // Backpressure: 8-pixel line into a 4-deep FIFO with ready low
        pix_ready = 1'b0;
        base = popq.size();
        for (int i = 0; i < 8; i++) begin
            dtick(1'b0, 1'b0, 1'b1, 24'h100 + 24'(i));
            if (i == 5) begin
                chk("bp_hold_data", pix_data, 24'h100);
                chk("bp_hold_x", pix_x, 0);
            end
        end
        dtick(1'b0, 1'b0, 1'b0, 24'h0);
        cyc(2);
        chk("bp_valid", pix_valid, 1);
        chk("bp_head_data", pix_data, 24'h100);
        chk("bp_head_y", pix_y, 0);
        chk("bp_ovf", overflow, 1);
        chk("bp_lerr", line_len_err, 1);
        chk("bp_ppl", last_ppl, 8);
        chk("bp_none_popped", popq.size() - base, 0);
        pix_ready = 1'b1;
        cyc(8);
        chk("bp_count", popq.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            chk("bp_x", popq[base + i].x, i);
            chk("bp_data", popq[base + i].d, 24'h100 + i);
        end
        dtick(1'b1, 1'b0, 1'b0, 24'h0);
        dtick(1'b0, 1'b0, 1'b0, 24'h0);
        chk("bp_ferr", frame_len_err, 1);
        chk("bp_lpp", last_lpp, 1);
        pulse_clr();
        chk("clr_lerr", line_len_err, 0);
        chk("clr_ferr", frame_len_err, 0);
        chk("clr_ovf", overflow, 0);

        // Line length mismatch: second line has 5 pixels
        base = popq.size();
        send_line(4, 24'h300);
        send_line(5, 24'h304);
        chk("mm_ppl5", last_ppl, 5);
        chk("mm_lerr", line_len_err, 1);
        send_line(4, 24'h309);
        dtick(1'b1, 1'b0, 1'b0, 24'h0);
        dtick(1'b0, 1'b0, 1'b0, 24'h0);
        cyc(4);
        chk("mm_count", popq.size() - base, 13);
        chk("mm_x4", popq[base + 8].x, 4);
        chk("mm_y1", popq[base + 8].y, 1);
        chk("mm_data", popq[base + 8].d, 24'h308);
        chk("mm_ppl_last", last_ppl, 4);
        chk("mm_lpp", last_lpp, 3);
        chk("mm_ferr", frame_len_err, 0);
        chk("mm_lerr_sticky", line_len_err, 1);
        pulse_clr();

        // Clear collides with a short-frame error: the set wins
        send_line(4, 24'h400);
        send_line(4, 24'h404);
        lcd_fp = 1'b1; lcd_lp = 1'b0; lcd_enab = 1'b0; lcd_vd = '0; lcd_dclk = 1'b0;
        cyc(2);
        lcd_dclk = 1'b1;
        cyc(2);
        sts_clr = 1'b1;
        cyc(1);
        sts_clr = 1'b0;
        chk("coll_ferr", frame_len_err, 1);
        chk("coll_lpp", last_lpp, 2);
        chk("coll_lerr", line_len_err, 0);
        cyc(1);
        pulse_clr();
        chk("coll_ferr_clr", frame_len_err, 0);
        dtick(1'b0, 1'b0, 1'b0, 24'h0);

        // Reset mid-frame with two pixels queued
        base = popq.size();
        send_line(4, 24'h500);
        pix_ready = 1'b0;
        dtick(1'b0, 1'b0, 1'b1, 24'h504);
        dtick(1'b0, 1'b0, 1'b1, 24'h505);
        cyc(2);
        chk("mr_valid_before", pix_valid, 1);
        chk("mr_popped", popq.size() - base, 4);
        reset = 1'b1;
        #1;
        chk("mr_valid_now", pix_valid, 0);
        chk("mr_data_zero", pix_data, 0);
        chk("mr_ppl_zero", last_ppl, 0);
        cyc(2);
        reset = 1'b0;
        pix_ready = 1'b1;
        dtick(1'b0, 1'b0, 1'b1, 24'h506);
        dtick(1'b0, 1'b0, 1'b1, 24'h507);
        dtick(1'b0, 1'b0, 1'b0, 24'h0);
        send_line(4, 24'h508);
        cyc(4);
        chk("mr_dropped", popq.size() - base, 4);
        chk("mr_idle_valid", pix_valid, 0);
        fd_base = fd_cnt;
        dtick(1'b1, 1'b0, 1'b0, 24'h0);
        dtick(1'b0, 1'b0, 1'b0, 24'h0);
        send_line(4, 24'h600);
        send_line(4, 24'h604);
        send_line(4, 24'h608);
        dtick(1'b1, 1'b0, 1'b0, 24'h0);
        dtick(1'b0, 1'b0, 1'b0, 24'h0);
        cyc(4);
        chk("mr_next_count", popq.size() - base, 16);
        chk("mr_first_x", popq[base + 4].x, 0);
        chk("mr_first_y", popq[base + 4].y, 0);
        chk("mr_first_data", popq[base + 4].d, 24'h600);
        chk("mr_last_x", popq[base + 15].x, 3);
        chk("mr_last_y", popq[base + 15].y, 2);
        chk("mr_last_data", popq[base + 15].d, 24'h60B);
        chk("mr_lpp", last_lpp, 3);
        chk("mr_ferr", frame_len_err, 0);
        chk("mr_lerr", line_len_err, 0);
        chk("mr_fdone", fd_cnt - fd_base, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
